uart_tx_sync: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_tx_sync.sv | 124 ++++++++++++
 tb/tb_uart_tx_sync.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter.
// Contents:
//   state_t  - frame FSM state encoding (3 bits)
//   TXD_IDLE - line level while no frame is being sent
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic TXD_IDLE = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   Clk      - system clock, rising edge
//   reset    - synchronous, active-high
//   clear    - holds the counter at zero (used while the line is idle)
//   bit_tick - high during the last cycle of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Decoded from the counter register; the FSM consumes it on the same edge
    // the counter wraps, so every bit lasts exactly CLKS_PER_BIT cycles.
    assign bit_tick = (cnt == LAST);

    always_ff @(posedge Clk) begin
        if (reset || clear || bit_tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_sync.sv
// UART-style serial transmitter: start bit, DATA_BITS data bits LSB first,
// optional even parity, stop bit. Idle line is high.
// Ports:
//   Clk      - system clock, rising edge
//   reset    - synchronous, active-high
//   tx_start - send request, accepted only while idle
//   tx_data  - payload, captured on the accepting edge
//   TxD      - serial line (registered)
//   tx_busy  - frame in progress (registered)
//   tx_done  - one-cycle pulse after the stop bit (registered)
module uart_tx_sync
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TxD,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t               state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 parity;
    logic                 bit_tick;
    logic                 timer_clear;

    // Timer is parked at zero while idle so the start bit gets a full period
    // counted from the accepting edge.
    assign timer_clear = (state == IDLE);
    assign shreg_nxt   = shreg >> 1;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .Clk     (Clk),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    // TxD is registered, so each transition loads the level of the bit that
    // starts on that edge rather than the one that is ending.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state   <= IDLE;
            TxD     <= TXD_IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    TxD <= TXD_IDLE;
                    if (tx_start) begin
                        shreg   <= tx_data;
                        parity  <= ^tx_data;
                        bit_cnt <= '0;
                        state   <= START;
                        TxD     <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state <= DATA;
                        TxD   <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                TxD   <= parity;
                            end else begin
                                state <= STOP;
                                TxD   <= TXD_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            shreg   <= shreg_nxt;
                            TxD     <= shreg_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state <= STOP;
                        TxD   <= TXD_IDLE;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state   <= IDLE;
                        TxD     <= TXD_IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    TxD     <= TXD_IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sync.sv
// Bench for uart_tx_sync: three instances (CPB=4 no parity, CPB=4 with parity,
// CPB=1 no parity) compared every cycle against a frame-level model, plus
// literal checks on specific frames.
module tb_uart_tx_sync;

    logic       clk;
    logic       rst;
    logic       st  [3];
    logic [7:0] dat [3];
    logic       txd [3];
    logic       busy[3];
    logic       done[3];

    int cpb[3] = '{4, 4, 1};
    int pen[3] = '{0, 1, 0};

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    uart_tx_sync #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0)) dut0 (
        .Clk(clk), .reset(rst), .tx_start(st[0]), .tx_data(dat[0]),
        .TxD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_sync #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1)) dut1 (
        .Clk(clk), .reset(rst), .tx_start(st[1]), .tx_data(dat[1]),
        .TxD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_sync #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY_EN(0)) dut2 (
        .Clk(clk), .reset(rst), .tx_start(st[2]), .tx_data(dat[2]),
        .TxD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, i, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is a list of bits; the line shows bit (t / CPB) where t counts
    // cycles since acceptance, and the frame ends after len*CPB cycles.
    logic       mvalid = 1'b0;
    logic       m_busy[3];
    logic       m_done[3];
    int         m_t   [3];
    logic [7:0] m_dat [3];

    function automatic int frame_len(input int i);
        return (8 + 2 + pen[i]) * cpb[i];
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int p, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && p != 0) return ^d;
        return 1'b1;
    endfunction

    function automatic logic exp_txd(input int i);
        if (!m_busy[i]) return 1'b1;
        return frame_bit(m_dat[i], pen[i], m_t[i] / cpb[i]);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_t[i]    <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (m_t[i] + 1 == frame_len(i)) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                    end
                    m_t[i] <= m_t[i] + 1;
                end else if (st[i]) begin
                    m_busy[i] <= 1'b1;
                    m_t[i]    <= 0;
                    m_dat[i]  <= dat[i];
                end
            end
        end
        if (rst) mvalid <= 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                check("txd",  i, 32'(txd[i]),  32'(exp_txd(i)));
                check("busy", i, 32'(busy[i]), 32'(m_busy[i]));
                check("done", i, 32'(done[i]), 32'(m_done[i]));
            end
        end
    end

    // ---------------- stimulus + literal checks ----------------
    initial begin
        logic [9:0] a5_bits;
        int nd, first, second;
        a5_bits = 10'b1101001010;  // 0,1,0,1,0,0,1,0,1,1 from bit 0 upward

        // Reset with tx_start asserted: nothing may start.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin st[i] = 1'b1; dat[i] = 8'hFF; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_txd",  i, 32'(txd[i]),  1);
            check("rst_busy", i, 32'(busy[i]), 0);
            check("rst_done", i, 32'(done[i]), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        repeat (3) @(negedge clk);

        // 8'hA5 on inst0 and 8'h07 with parity on inst1, launched together.
        st[0] = 1'b1; dat[0] = 8'hA5;
        st[1] = 1'b1; dat[1] = 8'h07;
        @(negedge clk);
        st[0] = 1'b0; st[1] = 1'b0;
        for (int k = 0; k <= 45; k++) begin
            if (k < 40)  check("a5_bit", 0, 32'(txd[0]), 32'(a5_bits[k/4]));
            if (k == 39) check("a5_busy_end", 0, 32'(busy[0]), 1);
            if (k == 40) begin
                check("a5_done", 0, 32'(done[0]), 1);
                check("a5_busy_off", 0, 32'(busy[0]), 0);
            end
            if (k == 41) check("a5_done_once", 0, 32'(done[0]), 0);
            if (k == 37) check("p07_parity", 1, 32'(txd[1]), 1);
            if (k == 43) check("p07_not_done", 1, 32'(done[1]), 0);
            if (k == 44) check("p07_done", 1, 32'(done[1]), 1);
            dat[0] = 8'($urandom); dat[1] = 8'($urandom);
            @(negedge clk);
        end

        // 8'h3C with an ignored start of 8'hFF at cycle 10.
        st[0] = 1'b1; dat[0] = 8'h3C;
        @(negedge clk);
        nd = 0;
        for (int k = 0; k <= 45; k++) begin
            if (k == 10) begin st[0] = 1'b1; dat[0] = 8'hFF; end
            else st[0] = 1'b0;
            if (k == 14) check("3c_bit2", 0, 32'(txd[0]), 1);
            if (k == 30) check("3c_bit6", 0, 32'(txd[0]), 0);
            if (done[0]) nd++;
            @(negedge clk);
        end
        check("3c_done_count", 0, 32'(nd), 1);

        // Reset at cycle 17 of a frame, then a clean 8'h81 frame.
        st[0] = 1'b1; dat[0] = 8'h81;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_txd",  0, 32'(txd[0]),  1);
        check("midrst_busy", 0, 32'(busy[0]), 0);
        nd = 0;
        for (int k = 0; k < 45; k++) begin
            if (done[0]) nd++;
            @(negedge clk);
        end
        check("midrst_no_done", 0, 32'(nd), 0);
        st[0] = 1'b1; dat[0] = 8'h81;
        @(negedge clk);
        st[0] = 1'b0;
        for (int k = 0; k <= 41; k++) begin
            if (k == 5)  check("81_bit0", 0, 32'(txd[0]), 1);
            if (k == 9)  check("81_bit1", 0, 32'(txd[0]), 0);
            if (k == 33) check("81_bit7", 0, 32'(txd[0]), 1);
            if (k == 40) check("81_done", 0, 32'(done[0]), 1);
            @(negedge clk);
        end

        // CPB=1 back-to-back: 8'h55 then 8'hAA with tx_start held.
        st[2] = 1'b1; dat[2] = 8'h55;
        @(negedge clk);
        dat[2] = 8'hAA;
        nd = 0; first = -1; second = -1;
        for (int k = 0; k < 30; k++) begin
            if (k == 1) check("55_bit0", 2, 32'(txd[2]), 1);
            if (done[2]) begin
                if (nd == 0) first = k; else second = k;
                nd++;
            end
            if (nd >= 1 && k == first)     check("b2b_gap_idle", 2, 32'(txd[2]), 1);
            if (nd >= 1 && k == first + 1) begin
                st[2] = 1'b0;
                check("b2b_start2", 2, 32'(txd[2]), 0);
            end
            if (nd >= 1 && k == first + 2) check("aa_bit0", 2, 32'(txd[2]), 0);
            if (nd >= 1 && k == first + 3) check("aa_bit1", 2, 32'(txd[2]), 1);
            @(negedge clk);
        end
        st[2] = 1'b0;
        check("b2b_done_count", 2, 32'(nd), 2);
        check("b2b_first_done", 2, 32'(first), 10);
        check("b2b_spacing", 2, 32'(second - first), 11);

        // Randomized traffic, including busy-time starts and rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                st[i]  = (i == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                dat[i] = 8'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
